// File: rtl/axi4_lite_register_bank_if.sv
// AXI4-Lite bus bundle for the register bank.
// Master drives requests; slave answers them.
interface axi4_lite_register_bank_if #(
  parameter int N = 4,
  parameter int A = 32
);
  logic [A-1:0]   awaddr;
  logic           awvalid;
  logic           awready;
  logic [8*N-1:0] wdata;
  logic [N-1:0]   wstrb;
  logic           wvalid;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready;
  logic [A-1:0]   araddr;
  logic           arvalid;
  logic           arready;
  logic [8*N-1:0] rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4_lite_register_bank.sv
// AXI4-Lite register bank: RW/RO/W1C registers, byte strobes, SLVERR.
// Define REG_BANK_IRQ_EN to build the registered W1C interrupt.
module axi4_lite_register_bank #(
  parameter int N = 4,
  parameter int A = 32,
  parameter int NUM_REGS = 8,
  parameter logic [2*NUM_REGS-1:0] MODE = '0,
  parameter logic [8*N*NUM_REGS-1:0] RESET_VAL = '0
) (
  input  logic aclk,
  input  logic aresetn,
  axi4_lite_register_bank_if.slave bus,
  output logic [8*N*NUM_REGS-1:0] reg_out,
  input  logic [8*N*NUM_REGS-1:0] reg_in,
  input  logic [8*N*NUM_REGS-1:0] reg_set,
  output logic [NUM_REGS-1:0] wr_pulse,
  output logic [NUM_REGS-1:0] rd_pulse,
  output logic irq
);
  localparam int D  = 8*N;
  localparam int LB = $clog2(N);
  localparam int IW = A - LB;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  function automatic logic [1:0] mode_of(input int i);
    return MODE[2*i +: 2];
  endfunction

  logic           aw_held_q, aw_held_d;
  logic [A-1:0]   aw_addr_q, aw_addr_d;
  logic           w_held_q, w_held_d;
  logic [D-1:0]   w_data_q, w_data_d;
  logic [N-1:0]   w_strb_q, w_strb_d;
  logic           bvalid_q, bvalid_d;
  logic [1:0]     bresp_q, bresp_d;
  logic           rvalid_q, rvalid_d;
  logic [1:0]     rresp_q, rresp_d;
  logic [D-1:0]   rdata_q, rdata_d;
  logic [D-1:0]   regs_q [NUM_REGS];
  logic [D-1:0]   regs_d [NUM_REGS];

  logic [IW-1:0]  aw_idx, ar_idx;
  logic           aw_ok, ar_ok, commit, ar_hs;
  logic [D-1:0]   bmask, clr, rd_val;
  logic           unused_ok;

  assign bus.awready = ~aw_held_q;
  assign bus.wready  = ~w_held_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = ~rvalid_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;

  assign unused_ok = ^{aw_addr_q[LB-1:0], bus.araddr[LB-1:0],
                       reg_in, reg_set};

  always_comb begin
    aw_idx = aw_addr_q[A-1:LB];
    ar_idx = bus.araddr[A-1:LB];
    aw_ok  = aw_idx < IW'(NUM_REGS);
    ar_ok  = ar_idx < IW'(NUM_REGS);
    commit = aw_held_q & w_held_q & ~bvalid_q;
    ar_hs  = bus.arvalid & ~rvalid_q;
    bmask  = '0;
    for (int b = 0; b < N; b++)
      bmask[8*b +: 8] = {8{w_strb_q[b]}};
    clr = w_data_q & bmask;
  end

  // Reads use the pre-edge register values, so a same-cycle write is unseen.
  always_comb begin
    rd_val   = '0;
    wr_pulse = '0;
    rd_pulse = '0;
    reg_out  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_pulse[i] = commit & aw_ok & (aw_idx == IW'(i));
      rd_pulse[i] = ar_hs & ar_ok & (ar_idx == IW'(i));
      reg_out[D*i +: D] = regs_q[i];
      regs_d[i] = regs_q[i];
      unique case (1'b1)
        mode_of(i) == 2'd1:
          regs_d[i] = '0;
        mode_of(i) == 2'd2:
          regs_d[i] = (regs_q[i] & ~(wr_pulse[i] ? clr : '0))
                    | reg_set[D*i +: D];
        default:
          if (wr_pulse[i])
            regs_d[i] = (regs_q[i] & ~bmask) | clr;
      endcase
      if (ar_idx == IW'(i))
        rd_val = (mode_of(i) == 2'd1) ? reg_in[D*i +: D] : regs_q[i];
    end
  end

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    if (bus.awvalid & ~aw_held_q) begin
      aw_held_d = 1'b1;
      aw_addr_d = bus.awaddr;
    end
    if (bus.wvalid & ~w_held_q) begin
      w_held_d = 1'b1;
      w_data_d = bus.wdata;
      w_strb_d = bus.wstrb;
    end
    if (bvalid_q & bus.bready)
      bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_ok ? OKAY : SLVERR;
    end
    if (rvalid_q & bus.rready)
      rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = ar_ok ? OKAY : SLVERR;
      rdata_d  = ar_ok ? rd_val : '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= (mode_of(i) == 2'd1) ? '0 : RESET_VAL[D*i +: D];
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= regs_d[i];
    end
  end

`ifdef REG_BANK_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (mode_of(i) == 2'd2)
        irq_d = irq_d | (|regs_q[i]);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: doc/axi4_lite_register_bank.md
# axi4_lite_register_bank

AXI4-Lite slave register bank with a configurable register count that need not be a power of two, and a per-register access mode: read/write, read-only, or write-1-to-clear. It adds byte-strobe writes, SLVERR on out-of-range addresses, per-register access pulses and an optional interrupt output. It replaces FIFO-buffered register files in control/status paths that need status capture and error reporting. It sits directly on an AXI4-Lite interconnect port.

## Interface
- N, 4: data bus bytes; 4 or 8. D = 8*N. LB = log2(N).
- A, 32: address width.
- NUM_REGS, 8: register count, 1..256.
- MODE, all 0: 2*NUM_REGS bits; field [2i+1:2i] gives the mode of register i. 0 = RW, 1 = RO, 2 = W1C, 3 = reserved (treated as RW).
- RESET_VAL, all 0: D*NUM_REGS bits; reset value of each RW/W1C register.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; synchronous, active-low.
- awaddr  in  A  write address. awvalid in 1. awready out 1.
- wdata  in  D  write data. wstrb in N. wvalid in 1. wready out 1.
- bresp  out  2  write response. bvalid out 1. bready in 1.
- araddr  in  A  read address. arvalid in 1. arready out 1.
- rdata  out  D  read data. rresp out 2. rvalid out 1. rready in 1.
- reg_out  out  D*NUM_REGS  current value of every register. RO slots read 0.
- reg_in  in  D*NUM_REGS  hardware value for RO registers; ignored for other modes.
- reg_set  in  D*NUM_REGS  per-bit set request for W1C registers.
- wr_pulse  out  NUM_REGS  one-cycle pulse when a write commits to register i.
- rd_pulse  out  NUM_REGS  one-cycle pulse when a read of register i is accepted.
- irq  out  1  interrupt; OR of all W1C bits (see Configuration).

## Operation
- Index: idx = addr[A-1:LB]. If idx >= NUM_REGS, the access is out of range. Low LB address bits are ignored.
- Write path:
  - Independent one-entry holding registers for AW and W. awready = ~aw_held; wready = ~w_held.
  - AW and W may arrive in either order or in the same cycle.
- Commit condition: aw_held & w_held & ~bvalid. On the commit edge:
  - RW: each byte lane with wstrb set is replaced by wdata.
  - W1C: for each strobed lane, bits written 1 clear; bits written 0 keep their value.
  - RO: no state change; bresp = OKAY.
  - Out of range: no state change; bresp = SLVERR (2'b10).
  - Otherwise bresp = OKAY (2'b00).
  - bvalid is set and both holding registers are cleared.
- wr_pulse[idx] is high in the commit cycle, in range only, including RO registers and wstrb = 0.
- W1C hardware set: every cycle, reg |= reg_set. Set and clear on the same bit in the same cycle: set wins, bit = 1.
- Read path: arready = ~rvalid. On the AR handshake edge:
  - rdata and rresp are captured and rvalid is set.
  - Register value: RW/W1C give the stored value; RO gives reg_in sampled at that edge.
  - Out of range: rdata = 0, rresp = SLVERR.
  - rd_pulse[idx] is high in the handshake cycle, in range only.
- A W1C register read returns its value without side effects.
- bvalid/rvalid clear on the edge where bready/rready is high.
- Read and write paths are independent. A read and a write to the same register in the same cycle: the read returns the pre-write value.

## Timing
- Reset values: awready = wready = arready = 1 in the first cycle after reset; bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0; RW/W1C registers = RESET_VAL; pulses = 0; irq = 0.
- Write latency: AW and W accepted at edge k; commit and bvalid high at edge k+1. Peak throughput is one write per 2 cycles with bready held high.
- Read latency: rvalid is high on the edge after arvalid & arready. Peak throughput is one read per 2 cycles with rready held high.
- Backpressure:
  - While bvalid & ~bready, the holding registers may fill but no commit occurs.
  - While rvalid & ~rready, arready = 0.
- Reset mid-transaction: all held and pending state is discarded, and every output returns to its reset value on the next edge.

## Configuration
- REG_BANK_IRQ_EN defined: irq is a registered OR of every bit of every W1C register. It rises one cycle after a bit sets and falls one cycle after the last bit clears.
- REG_BANK_IRQ_EN undefined: irq is tied to 0 and the OR tree is not built.

## Test plan
- Reset with NUM_REGS = 5, reg 0 RW, RESET_VAL = 0x1234_5678, then read 0x0 -> rdata = 0x12345678, rresp = 0. Ready outputs = 1 after reset.
- Write 0xAABBCCDD, wstrb = 4'b0101, to RW reg 0 -> reg 0 = 0x12BB56DD, bresp = 0, wr_pulse[0] for one cycle. Repeat with W issued 3 cycles before AW -> same result.
- W1C reg 2: reg_set = 0x0000_00F0 for one cycle; write 0x30 with wstrb = 4'hF -> reg 2 = 0xC0. Simultaneous set and clear of bit 7 -> bit 7 stays 1. With the macro, irq = 1 until the bank is zero.
- RO reg 3 with reg_in = 0xDEADBEEF: write 0 -> bresp = OKAY, reg_in unaffected; read -> 0xDEADBEEF.
- Out-of-range: write to 0x14 (idx 5) -> bresp = 2'b10, no register changes; read 0x14 -> rdata = 0, rresp = 2'b10.
- Hold bready = 0 for 10 cycles with two writes queued -> second write is not committed, awready/wready = 0 after the holds fill. Releasing bready commits the second write 1 cycle after the first B handshake.
